// File: rtl/store_aligner.sv
// store_aligner: splits byte/half/word stores into one or two word-aligned
// memory beats with byte-lane enables, handshaking on mem_req/mem_gnt.
module store_aligner #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  st_valid,
  output logic                  st_ready,
  input  logic [ADDR_WIDTH-1:0] st_addr,
  input  logic [DATA_WIDTH-1:0] st_data,
  input  logic [1:0]            st_size,
  output logic                  st_done,
  output logic                  st_err,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_be,
  input  logic                  mem_gnt
);
  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic [1:0]            r_size;
  logic                  r_err;
  logic [35:0]           w_lo;
  logic [35:0]           w_hi;

  // Returns {be, wdata} for the low or high word of the 64-bit shifted store.
  function automatic logic [35:0] lane(input logic hi, input logic [1:0] off,
                                       input logic [1:0] size, input logic [31:0] data);
    logic [3:0]  mask;
    logic [31:0] d;
    logic [63:0] wide;
    logic [7:0]  be8;
    mask = size == 2'b00 ? 4'b0001 : size == 2'b01 ? 4'b0011 : 4'b1111;
    d    = data & {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
    wide = {32'h0, d} << {off, 3'b000};
    be8  = {4'h0, mask} << off;
    return hi ? {be8[7:4], wide[63:32]} : {be8[3:0], wide[31:0]};
  endfunction

  assign w_lo = lane(1'b0, st_addr[1:0], st_size, st_data);
  assign w_hi = lane(1'b1, r_addr[1:0], r_size, r_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_data    <= '0;
      r_size    <= '0;
      r_err     <= 1'b0;
      st_ready  <= 1'b1;
      st_done   <= 1'b0;
      st_err    <= 1'b0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
    end else begin
      case (r_state)
        IDLE: if (st_valid) begin
          r_addr   <= st_addr;
          r_data   <= st_data;
          r_size   <= st_size;
          r_err    <= &st_size;
          st_ready <= 1'b0;
          if (&st_size) begin
            r_state <= DONE;
            st_done <= 1'b1;
            st_err  <= 1'b1;
          end else begin
            r_state   <= BEAT0;
            mem_req   <= 1'b1;
            mem_addr  <= {st_addr[ADDR_WIDTH-1:2], 2'b00};
            mem_wdata <= w_lo[31:0];
            mem_be    <= w_lo[35:32];
          end
        end
        BEAT0: if (mem_gnt) begin
          if (|w_hi[35:32]) begin
            r_state   <= BEAT1;
            mem_addr  <= {r_addr[ADDR_WIDTH-1:2], 2'b00} + ADDR_WIDTH'(4);
            mem_wdata <= w_hi[31:0];
            mem_be    <= w_hi[35:32];
          end else begin
            r_state   <= DONE;
            mem_req   <= 1'b0;
            mem_wdata <= '0;
            mem_be    <= '0;
            st_done   <= 1'b1;
            st_err    <= r_err;
          end
        end
        BEAT1: if (mem_gnt) begin
          r_state   <= DONE;
          mem_req   <= 1'b0;
          mem_wdata <= '0;
          mem_be    <= '0;
          st_done   <= 1'b1;
          st_err    <= r_err;
        end
        DONE: begin
          r_state  <= IDLE;
          st_done  <= 1'b0;
          st_err   <= 1'b0;
          st_ready <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_store_aligner.sv
// tb_store_aligner: scoreboard bench; a byte-by-byte store model predicts beats
// and completions, a monitor compares them as the DUT presents them.
module tb_store_aligner;
  logic        clk = 0, rst_n = 0, st_valid = 0, mem_gnt = 0;
  logic        st_ready, st_done, st_err, mem_req;
  logic [31:0] st_addr = 0, st_data = 0, mem_addr, mem_wdata;
  logic [1:0]  st_size = 0;
  logic [3:0]  mem_be;

  typedef struct {logic [31:0] a; logic [3:0] be; logic [31:0] d;} beat_t;
  beat_t bq[$];
  bit    eq[$];
  int    vec = 0, errs = 0;
  bit    gnt_rand = 0, gnt_force = 1;

  store_aligner dut (
    .clk(clk), .rst_n(rst_n), .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_data(st_data), .st_size(st_size), .st_done(st_done),
    .st_err(st_err), .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_gnt(mem_gnt)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Each stored byte k lands at address addr+k; bytes are grouped by the word they fall in.
  task automatic model(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    beat_t       b[2];
    logic [31:0] ba, w0;
    int          n;
    if (sz == 2'd3) begin
      eq.push_back(1'b1);
      return;
    end
    n  = 1 << sz;
    w0 = a & ~32'h3;
    for (int i = 0; i < 2; i++) begin
      b[i].a  = w0 + 32'(4 * i);
      b[i].be = '0;
      b[i].d  = '0;
    end
    for (int k = 0; k < n; k++) begin
      int idx, ln;
      ba  = a + 32'(k);
      idx = ((ba & ~32'h3) == w0) ? 0 : 1;
      ln  = int'(ba[1:0]);
      b[idx].be[ln]       = 1'b1;
      b[idx].d[8*ln +: 8] = d[8*k +: 8];
    end
    bq.push_back(b[0]);
    if (b[1].be != 0) bq.push_back(b[1]);
    eq.push_back(1'b0);
  endtask

  task automatic cyc();
    @(negedge clk);
    mem_gnt = gnt_rand ? ($urandom_range(0, 2) != 0) : gnt_force;
  endtask

  task automatic send(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    st_valid = 1; st_size = sz; st_addr = a; st_data = d;
    while (!st_ready && n < 100) begin
      cyc();
      n++;
    end
    if (st_ready) model(sz, a, d);
    else chk("accept_timeout", 64'd0, 64'd1);
    cyc();
    st_valid = 0; st_addr = $urandom; st_data = $urandom; st_size = 2'($urandom);
  endtask

  task automatic lat(input string nm, input int exp);
    int n = 0;
    while (!st_done && n < 20) begin
      cyc();
      n++;
    end
    chk(nm, 64'(n), 64'(exp));
  endtask

  initial begin
    logic        pr = 0, pg = 0;
    logic [31:0] pa = 0, pd = 0;
    logic [3:0]  pb = 0;
    beat_t       e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) pr = 0;
      else begin
        if (mem_req) begin
          if (pr && !pg) begin
            chk("hold_addr_data", {mem_addr, mem_wdata}, {pa, pd});
            chk("hold_be", 64'(mem_be), 64'(pb));
          end
          if (mem_gnt) begin
            if (bq.size() == 0) chk("unexpected_beat", 64'd1, 64'd0);
            else begin
              e = bq.pop_front();
              chk("beat_addr", 64'(mem_addr), 64'(e.a));
              chk("beat_be_data", {28'h0, mem_be, mem_wdata}, {28'h0, e.be, e.d});
            end
          end
        end else chk("idle_lanes", {28'h0, mem_be, mem_wdata}, 64'd0);
        if (st_done) begin
          if (eq.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
          else chk("done_err", 64'(st_err), 64'(eq.pop_front()));
        end
        pr = mem_req; pg = mem_gnt; pa = mem_addr; pd = mem_wdata; pb = mem_be;
      end
    end
  end

  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    int          n;
    repeat (2) cyc();
    chk("reset_ctl", {60'h0, st_ready, st_done, st_err, mem_req}, {60'h0, 4'b1000});
    chk("reset_bus", {mem_addr, mem_wdata}, 64'd0);
    chk("reset_be", 64'(mem_be), 64'd0);
    rst_n = 1;
    send(2'd2, 32'h100, 32'hDEADBEEF);
    chk("sw_beat0", {28'h0, mem_addr, mem_be}, {28'h0, 32'h100, 4'hF});
    lat("sw_lat", 1);
    send(2'd0, 32'h103, 32'h000000AB);
    chk("sb_beat", {28'h0, mem_be, mem_wdata}, {28'h0, 4'h8, 32'hAB000000});
    lat("sb_lat", 1);
    send(2'd1, 32'h103, 32'h00001234);
    lat("sh_lat", 2);
    send(2'd2, 32'hFFFFFFFE, 32'h11223344);
    chk("wrap_beat0", {mem_addr, mem_wdata}, {32'hFFFFFFFC, 32'h33440000});
    cyc();
    chk("wrap_beat1", {mem_addr, mem_wdata}, {32'h00000000, 32'h00001122});
    lat("wrap_lat", 1);
    send(2'd3, 32'h40, 32'h5);
    chk("ill_noreq", 64'(mem_req), 64'd0);
    lat("ill_lat", 0);
    chk("ill_err", 64'(st_err), 64'd1);
    gnt_force = 0;
    send(2'd2, 32'h200, 32'hCAFEF00D);
    cyc();
    cyc();
    chk("stall_busy", {62'h0, st_ready, mem_req}, {62'h0, 2'b01});
    gnt_force = 1;
    lat("stall_lat", 2);
    send(2'd1, 32'h3, 32'h0000BEEF);
    cyc();
    chk("split_beat1_be", 64'(mem_be), 64'h1);
    rst_n = 0;
    #1;
    chk("rst_abort", {60'h0, mem_req, st_ready, st_done, |mem_be}, {60'h0, 4'b0100});
    bq.delete();
    eq.delete();
    cyc();
    cyc();
    rst_n = 1;
    gnt_rand = 1;
    repeat (150) begin
      sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a  = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFFC | 32'($urandom_range(0, 3))) : $urandom;
      send(sz, a, $urandom);
      repeat ($urandom_range(0, 2)) cyc();
    end
    n = 0;
    while ((bq.size() != 0 || eq.size() != 0) && n < 500) begin
      cyc();
      n++;
    end
    chk("drain", 64'(bq.size() + eq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule

// File: doc/store_aligner.md
STORE_ALIGNER -- requirements
Module: store_aligner

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the data path width; only 32 is supported.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 32, giving the byte-address width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port st_valid, input, 1 bit: a store request is present.
REQ-006 The block SHALL have port st_ready, output, 1 bit: the block can accept a request.
REQ-007 The block SHALL have port st_addr, input, ADDR_WIDTH bits: the byte address of the store.
REQ-008 The block SHALL have port st_data, input, DATA_WIDTH bits: the store value, least-significant-aligned.
REQ-009 The block SHALL have port st_size, input, 2 bits: 00 byte, 01 half-word, 10 word, 11 illegal.
REQ-010 The block SHALL have port st_done, output, 1 bit: one-cycle pulse when the store completes.
REQ-011 The block SHALL have port st_err, output, 1 bit: valid with st_done; set for an illegal size.
REQ-012 The block SHALL have port mem_req, output, 1 bit: a memory write beat is presented.
REQ-013 The block SHALL have port mem_addr, output, ADDR_WIDTH bits: the word-aligned beat address (bits [1:0] = 00).
REQ-014 The block SHALL have port mem_wdata, output, DATA_WIDTH bits: the lane-aligned write data.
REQ-015 The block SHALL have port mem_be, output, 4 bits: the byte-lane write enables (bit i enables byte i).
REQ-016 The block SHALL have port mem_gnt, input, 1 bit: memory accepts the beat in the cycle where mem_req and mem_gnt are both 1.

Function
REQ-017 The FSM SHALL have states IDLE, BEAT0, BEAT1, DONE.
REQ-018 st_ready SHALL be 1 only in IDLE.
REQ-019 Acceptance SHALL occur when st_valid and st_ready are both 1; at acceptance the block latches addr, data and size.
REQ-020 On acceptance with size 11, the FSM SHALL go to DONE with error flagged and no mem_req; otherwise it goes to BEAT0.
REQ-021 Lane math SHALL use off = addr[1:0], wide64 = zero-extended data << 8*off, be8 = mask << off, where mask = 0001 for byte, 0011 for half-word, 1111 for word.
REQ-022 In BEAT0, the block SHALL drive mem_req=1, mem_addr = {addr[ADDR_WIDTH-1:2],00}, mem_wdata = wide64[31:0], mem_be = be8[3:0].
REQ-023 BEAT0 SHALL transition on grant: to BEAT1 if be8[7:4] != 0, else to DONE.
REQ-024 In BEAT1, the block SHALL drive mem_req=1, mem_addr = BEAT0 address + 4, wrapping modulo 2^ADDR_WIDTH, mem_wdata = wide64[63:32], mem_be = be8[7:4]; on grant it goes to DONE.
REQ-025 While mem_req=1 and mem_gnt=0, mem_addr, mem_wdata and mem_be SHALL hold stable.
REQ-026 Byte lanes with mem_be bit 0 SHALL drive 8'h00 in mem_wdata.
REQ-027 In DONE, the block SHALL output st_done=1 and st_err = error flag for exactly one cycle, then go to IDLE.
REQ-028 Outside DONE, st_done and st_err SHALL be 0; outside BEAT0/BEAT1, mem_req, mem_be and mem_wdata SHALL be 0.
REQ-029 Latency with mem_gnt held at 1: acceptance in cycle N, BEAT0 in N+1, BEAT1 (if split) in N+2, st_done one cycle after the last beat.
REQ-030 The block SHALL ignore st_valid outside IDLE; a request held across busy cycles is accepted on the return to IDLE.
REQ-031 mem_gnt SHALL be ignored when mem_req=0.

Reset
REQ-032 While rst_n=0, the FSM SHALL be in IDLE, with st_ready=1, and st_done, st_err, mem_req, mem_be, mem_wdata, mem_addr and the latched registers all 0.
REQ-033 Assertion of rst_n SHALL abort any in-flight store immediately, including mid-split, without a completing st_done; mem_req falls asynchronously.

Verification
REQ-034 SW, addr 0x100, data 0xDEADBEEF, gnt=1 -> one beat: addr 0x100, be 1111, wdata 0xDEADBEEF; st_done two cycles after acceptance, st_err=0.
REQ-035 SB, addr 0x103, data 0x000000AB -> one beat: addr 0x100, be 1000, wdata 0xAB000000.
REQ-036 SH, addr 0x103, data 0x00001234 -> beat0: addr 0x100, be 1000, wdata 0x34000000; beat1: addr 0x104, be 0001, wdata 0x00000012; then st_done.
REQ-037 SW, addr 0xFFFFFFFE, data 0x11223344 -> beat0: addr 0xFFFFFFFC, be 1100, wdata 0x33440000; beat1: addr 0x00000000, be 0011, wdata 0x00001122.
REQ-038 SW with mem_gnt=0 for 3 cycles -> mem_req and all beat outputs stable for 4 cycles; st_ready=0 throughout; st_done after the grant.
REQ-039 st_size=11 -> no mem_req, st_done=1 with st_err=1 one cycle after acceptance; rst_n low during BEAT1 -> mem_req=0 immediately, no st_done, IDLE with st_ready=1.
